// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: a per-register countdown scoreboard for an N-wide in-order issue stage.
// Optional counters (stall_cycles, jr_count) are built when HAZARD_STALL_CNT_EN is defined.
module load_use_scoreboard #(
  parameter int ISSUE_W  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISSUE_W-1:0]   valid_id,
  input  logic [5*ISSUE_W-1:0] rs_id,
  input  logic [5*ISSUE_W-1:0] rt_id,
  input  logic [ISSUE_W-1:0]   uses_rt_id,
  input  logic [5*ISSUE_W-1:0] dest_id,
  input  logic [ISSUE_W-1:0]   reg_write_id,
  input  logic [ISSUE_W-1:0]   mem_read_id,
  input  logic                 jr_id,
  input  logic                 flush,
  output logic                 ld_stall,
  output logic                 jr_bubble,
  output logic [31:0]          pend_mask
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          jr_count
`endif
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      pend;
  logic             src_pend;
  logic             issue;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++) begin
      pend[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    src_pend = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (valid_id[i] &&
          (pend[rs_id[5*i +: 5]] || (uses_rt_id[i] && pend[rt_id[5*i +: 5]]))) begin
        src_pend = 1'b1;
      end
    end
    if (valid_id[0] && jr_id && pend[rs_id[4:0]]) begin
      src_pend = 1'b1;
    end
  end

  assign ld_stall  = !flush && src_pend;
  assign issue     = !ld_stall && !flush;
  assign jr_bubble = issue && valid_id[0] && jr_id;
  assign pend_mask = pend;

  // Lanes are walked oldest to youngest so the youngest writer of a register wins.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE : cnt_q[r];
    end
    if (issue) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (valid_id[i] && reg_write_id[i]) begin
          cnt_d[dest_id[5*i +: 5]] = mem_read_id[i] ? LOAD_CNT : '0;
        end
      end
    end
    cnt_d[0] = '0;
  end

  // NOTE: this small register array is reset (unlike a RAM) because a stale count after reset would cause phantom stalls.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] jr_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      jr_count_q     <= '0;
    end else begin
      if (ld_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (jr_bubble) begin
        jr_count_q <= jr_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign jr_count     = jr_count_q;
`endif

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

- Parametrised load-use hazard unit for the N-wide in-order issue pipeline.
- Replaces the fixed two-lane, one-cycle-latency comparator with a per-register countdown scoreboard, so it supports any issue width and any load-to-forward latency.
- Sits beside the ID stage. Each cycle it receives the issuing bundle's sources and destinations and drives a single stall to PC/IF/ID.
- Generates the jump-register bubble request.

## Interface
- ISSUE_W, 2: lanes per bundle (1–4)
- LOAD_LAT, 1: cycles a load result is unavailable for forwarding after the load leaves ID (1–7)
- CNT_W, 3: scoreboard counter width; must satisfy 2^CNT_W > LOAD_LAT
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- valid_id  in  ISSUE_W  lane i holds a real instruction
- rs_id  in  5*ISSUE_W  lane i rs at bits [5i+4:5i]
- rt_id  in  5*ISSUE_W  lane i rt
- uses_rt_id  in  ISSUE_W  lane i reads rt (R-type/branch/store)
- dest_id  in  5*ISSUE_W  lane i destination register
- reg_write_id  in  ISSUE_W  lane i writes dest
- mem_read_id  in  ISSUE_W  lane i is a load
- jr_id  in  1  lane 0 holds jr (only lane 0 may)
- flush  in  1  ID bundle killed this cycle (branch/jump redirect)
- ld_stall  out  1  hold PC/IF/ID, inject bubble into EX
- jr_bubble  out  1  jr leaves ID this cycle; fetch must insert one bubble
- pend_mask  out  32  bit r set while scoreboard counter r is non-zero (debug)

## Operation
- Scoreboard: 31 counters cnt[1..31], each CNT_W bits. Register 0 is never tracked and always reads 0.
- Source pending:
  - src_pend(i) = valid_id[i] && (cnt[rs_i]!=0 || (uses_rt_id[i] && cnt[rt_i]!=0)).
  - jr additionally checks cnt[rs_0].
- ld_stall = !flush && OR over lanes of src_pend(i). Purely combinational from inputs and state.
- issue = !ld_stall && !flush. The whole bundle advances or holds together; there is no partial issue.
- jr_bubble = issue && valid_id[0] && jr_id.
- Counter update per register r, every clock edge, evaluated in priority order:
  1. if issue and some valid lane has reg_write_id && dest==r: cnt[r] <= mem_read_id of the highest-numbered such lane ? LOAD_LAT : 0. A younger non-load write cancels an older pending load.
  2. else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  3. else hold.
- Set beats decrement in the same cycle.
- Counters continue decrementing during stall and flush. Loads already issued still complete.
- Dependencies inside one bundle are excluded by the issue unit and are not checked here.
- pend_mask[r] = (cnt[r]!=0); pend_mask[0] = 0.

## Timing
- Reset (rst low, asynchronous): all cnt = 0, so ld_stall = 0, jr_bubble = 0, pend_mask = 0. Release is synchronous to the next clk edge.
- A load issued at edge t gives a dependent instruction in ID exactly LOAD_LAT stall cycles. It issues at edge t+LOAD_LAT+1.
- A dependent instruction arriving k cycles after the load stalls max(0, LOAD_LAT-k+1) cycles.
- ld_stall and jr_bubble are same-cycle with no registered latency. Stall duration is bounded by LOAD_LAT.
- flush with a pending hazard: ld_stall = 0 and nothing is recorded that cycle.
- Reset mid-stall drops all pending state immediately.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - adds output stall_cycles [31:0]: increments on every cycle with ld_stall=1, saturates at 0xFFFFFFFF, resets to 0.
  - adds output jr_count [15:0]: increments on jr_bubble, wraps.
- Undefined: both ports and their logic are absent. Hazard behaviour is identical in both builds.

## Test plan
- ISSUE_W=2, LOAD_LAT=1: lane1 lw $5 issues; next bundle lane0 add $6,$5,$1 -> ld_stall=1 for exactly 1 cycle, issue on the following edge.
- LOAD_LAT=3: lw $9, then one independent bundle, then a $9 consumer -> 2 stall cycles; pend_mask[9] observed as 1,1,1,0 across the 4 cycles after the load issues.
- lw $4 then next bundle lane0 jr $4 -> ld_stall=1 and jr_bubble=0 for 1 cycle, then jr_bubble=1 for 1 cycle.
- lw $7 in lane0 and addi $7 in lane1 of the same bundle -> cnt[7]=0; a $7 consumer next cycle sees no stall.
- Consumer in ID with a pending hazard and flush=1 -> ld_stall=0; lw $0 -> never stalls; rst asserted mid-stall -> ld_stall=0 asynchronously.
- With HAZARD_STALL_CNT_EN: 5 forced stall cycles -> stall_cycles=5; preload near 0xFFFFFFFF and confirm it saturates.
